det_stream_sched: RTL and testbench

//   Round-robin scheduler that shares one 1101 Moore pattern detector between NREQ word sources.
//   - Accepts a WIDTH-bit word from the winning requester.
//   - Shifts the word MSB-first into the detector.
//   - Counts overlapping 1101 matches within that word.
//   - Reports the count with a one-cycle done pulse tagged by requester ID.
//   - Sits between pushbutton/UART word sources and the seven-segment/LED display logic in top.

---
 rtl/det_pkg.sv | 22 ++
 rtl/det1101_en.sv | 40 ++++
 rtl/det_stream_sched.sv | 131 +++++++++++++
 tb/tb_det_stream_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared types for the 1101 stream scheduler.
// Holds the detector states, scheduler states and the match pattern.
package det_pkg;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } sched_state_t;

  localparam logic [3:0] DET_PATTERN = 4'b1101;

endpackage

// File: rtl/det1101_en.sv
// Enabled, synchronously clearable 1101 Moore detector (overlap allowed).
// clr has priority over en; state is held while en is low.
module det1101_en
  import det_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  input  logic i,
  output logic o
);

  det_state_t r_st;
  det_state_t w_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_st <= S0;
    else        r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    if (clr) begin
      w_nxt = S0;
    end else if (en) begin
      unique case (r_st)
        S0: w_nxt = (i == DET_PATTERN[3]) ? S1 : S0;
        S1: w_nxt = (i == DET_PATTERN[2]) ? S2 : S0;
        S2: w_nxt = (i == DET_PATTERN[1]) ? S3 : S2;
        S3: w_nxt = (i == DET_PATTERN[0]) ? S4 : S0;
        S4: w_nxt = i ? S2 : S0;
        default: w_nxt = S0;
      endcase
    end
  end

  assign o = (r_st == S4);

endmodule

// File: rtl/det_stream_sched.sv
// Round-robin scheduler feeding NREQ word sources through one 1101 detector.
// Each granted word is shifted MSB-first and its match count reported on done.
module det_stream_sched
  import det_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 8,
  parameter  int CNTW  = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    bit_out,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [CNTW-1:0]         match_cnt
);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [BW-1:0]    r_idx;
  logic [IDW-1:0]   r_last;
  logic [CNTW-1:0]  r_cnt;
  logic [CNTW-1:0]  w_cnt_nxt;
  logic             r_en_d;
  logic             w_en;
  logic             w_clr;
  logic             w_det_o;
  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [NREQ-1:0]  w_gnt;
  logic [WIDTH-1:0] w_word;

  // Two passes: indices above r_last first, then wrap to 0..r_last.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_gnt  = '0;
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && req[i] && (i > int'(r_last))) begin
        w_any    = 1'b1;
        w_win    = IDW'(i);
        w_gnt[i] = 1'b1;
        w_word   = data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && req[i] && (i <= int'(r_last))) begin
        w_any    = 1'b1;
        w_win    = IDW'(i);
        w_gnt[i] = 1'b1;
        w_word   = data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = SHIFT;
      SHIFT:   if (r_idx == '0) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_en    = (r_state == SHIFT);
  assign w_clr   = (r_state == IDLE) && w_any;
  assign gnt     = (n_rst && r_state == IDLE) ? w_gnt : '0;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign bit_out = w_en ? r_word[r_idx] : 1'b0;

  // en_d marks cycles where the detector output reflects a shifted bit.
  assign w_cnt_nxt = (r_en_d && w_det_o && (r_cnt != '1))
                   ? r_cnt + 1'b1 : r_cnt;

  det1101_en u_det (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (w_en),
    .clr   (w_clr),
    .i     (bit_out),
    .o     (w_det_o)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_idx     <= '0;
      r_last    <= IDW'(NREQ - 1);
      r_cnt     <= '0;
      r_en_d    <= 1'b0;
      match_cnt <= '0;
      done_id   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= w_en;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_word <= w_word;
            r_last <= w_win;
            r_cnt  <= '0;
            r_idx  <= BW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          r_idx <= r_idx - 1'b1;
          r_cnt <= w_cnt_nxt;
        end
        FLUSH: begin
          r_cnt     <= w_cnt_nxt;
          match_cnt <= w_cnt_nxt;
          done_id   <= r_last;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det_stream_sched.sv
// Scoreboard bench for det_stream_sched: directed words plus random traffic,
// with a second instance at CNTW=1 to exercise count saturation.
module tb_det_stream_sched;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;

  logic [NREQ-1:0] gnt, gnt_s;
  logic            busy, busy_s;
  logic            bit_out, bit_s;
  logic            done, done_s;
  logic [0:0]      done_id, done_id_s;
  logic [CNTW-1:0] match_cnt;
  logic [0:0]      match_cnt_s;

  det_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .data(data),
    .gnt(gnt), .busy(busy), .bit_out(bit_out), .done(done),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  det_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(1)) dut_s (
    .clk(clk), .n_rst(n_rst), .req(req), .data(data),
    .gnt(gnt_s), .busy(busy_s), .bit_out(bit_s), .done(done_s),
    .done_id(done_id_s), .match_cnt(match_cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int due;
  } exp_t;

  exp_t            q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              m_busy = 0;
  int              m_last = NREQ - 1;
  int              m_win;
  int              m_k;
  logic [NREQ-1:0] m_gnt = '0;
  logic [WIDTH-1:0] m_word = '0;
  logic            mon_e;
  exp_t            mon_x;

  function automatic int count_1101(logic [WIDTH-1:0] w);
    int c = 0;
    for (int p = WIDTH - 1; p >= 3; p--)
      if (w[p -: 4] == 4'b1101) c++;
    return c;
  endfunction

  function automatic int sat(int c, int bits);
    int m = (1 << bits) - 1;
    return (c > m) ? m : c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: grant/busy/bit_out timing and expected results.
  always @(negedge clk) begin
    m_gnt = '0;
    if (!n_rst) begin
      q.delete();
      m_busy = 0;
      m_last = NREQ - 1;
      chk("reset_outs",
          {22'd0, gnt, busy, bit_out, done, done_id, match_cnt},
          32'd0);
      chk("reset_outs_sat",
          {27'd0, gnt_s, busy_s, done_s, match_cnt_s}, 32'd0);
    end else if (m_busy == 0) begin
      m_win = -1;
      for (int k = 1; k <= NREQ; k++)
        if (m_win < 0 && req[(m_last + k) % NREQ])
          m_win = (m_last + k) % NREQ;
      if (m_win >= 0) m_gnt[m_win] = 1'b1;
      chk("gnt", gnt, m_gnt);
      chk("idle_busy_bit", {busy, bit_out}, 2'b00);
      if (m_win >= 0) begin
        m_word = data[m_win*WIDTH +: WIDTH];
        q.push_back('{id: m_win, cnt: count_1101(m_word),
                      due: cyc + WIDTH + 2});
        m_last = m_win;
        m_busy = WIDTH + 2;
      end
    end else begin
      m_k = WIDTH + 3 - m_busy;
      chk("gnt_off", gnt, '0);
      chk("busy", busy, 1);
      chk("bit_out", bit_out,
          (m_k <= WIDTH) ? m_word[WIDTH - m_k] : 1'b0);
      m_busy--;
    end
  end

  // Monitor: done must appear exactly when the head result falls due.
  always @(negedge clk) begin
    if (n_rst) begin
      mon_e = (q.size() > 0) && (q[0].due == cyc);
      chk("done", done, mon_e);
      chk("done_sat", done_s, mon_e);
      if (mon_e) begin
        mon_x = q.pop_front();
        chk("done_id", done_id, mon_x.id);
        chk("match_cnt", match_cnt, sat(mon_x.cnt, CNTW));
        chk("match_cnt_sat", match_cnt_s, sat(mon_x.cnt, 1));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve(int i, logic [WIDTH-1:0] w);
    data[i*WIDTH +: WIDTH] = w;
    req[i] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      if (m_gnt[i]) break;
    end
    chk("grant_wait", m_gnt[i], 1);
    #1;
    req[i] = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    req   = '0;
    data  = '0;
    tick(3);
    n_rst = 1'b1;
    tick(1);

    serve(0, 8'hDA);
    tick(WIDTH + 3);

    data = {8'hFF, 8'h0D};
    req  = 2'b11;
    tick(4 * (WIDTH + 3) + 2);
    req  = '0;
    tick(WIDTH + 4);

    serve(0, 8'hDB);
    serve(1, 8'h00);
    serve(0, 8'hD0);
    serve(0, 8'h1D);
    tick(WIDTH + 4);

    serve(0, 8'hDA);
    tick(3);
    n_rst = 1'b0;
    data  = {8'hB6, 8'h6D};
    req   = 2'b11;
    tick(2);
    n_rst = 1'b1;
    tick(3 * (WIDTH + 3));
    req   = '0;
    tick(WIDTH + 4);

    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_gnt[i]) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req[i] = 1'b1;
        end
      end
      if (c == 1000) begin
        n_rst = 1'b0;
        tick(1);
        n_rst = 1'b1;
      end
      tick(1);
    end
    req = '0;
    tick(2 * (WIDTH + 3));
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
